// File: rtl/fpu_cmd_sequencer_if.sv
// fpu_cmd_sequencer_if: request, response and ALU command signals of the FPU command sequencer.
//   req_*  : valid/ready request from the front-end (opcode, operand a/b, tag)
//   rsp_*  : valid/ready response to the front-end (result, flags, tag)
//   alu_*  : opcode/operands towards the ALU and result/flags/done back from it
//   master : front-end + ALU view; slave : sequencer view
interface fpu_cmd_sequencer_if #(parameter int TAG_W = 4);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_opcode;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [TAG_W-1:0] req_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_result;
  logic [4:0]       rsp_flags;
  logic [TAG_W-1:0] rsp_tag;
  logic [2:0]       alu_opcode;
  logic [31:0]      alu_op_a;
  logic [31:0]      alu_op_b;
  logic [31:0]      alu_result;
  logic             alu_exception;
  logic             alu_overflow;
  logic             alu_underflow;
  logic             alu_done;
  modport master (
    output req_valid, req_opcode, req_a, req_b, req_tag, rsp_ready,
           alu_result, alu_exception, alu_overflow, alu_underflow, alu_done,
    input  req_ready, rsp_valid, rsp_result, rsp_flags, rsp_tag,
           alu_opcode, alu_op_a, alu_op_b
  );
  modport slave (
    input  req_valid, req_opcode, req_a, req_b, req_tag, rsp_ready,
           alu_result, alu_exception, alu_overflow, alu_underflow, alu_done,
    output req_ready, rsp_valid, rsp_result, rsp_flags, rsp_tag,
           alu_opcode, alu_op_a, alu_op_b
  );
endinterface

// File: rtl/fpu_cmd_sequencer.sv
// fpu_cmd_sequencer: issues one FP request at a time to the ALU and returns result/flags with the caller tag.
//   clk, reset (async, active-high) : clock and reset
//   bus (slave)                     : req_* in, rsp_* out, alu_* command/result
//   busy                            : sequencer not idle
//   FPU_SEQ_LATENCY_EN (macro)      : adds rsp_latency[7:0] (ISSUE entry to capture, saturating)
//                                     and stat_timeouts[15:0] (saturating timeout count)
module fpu_cmd_sequencer #(
  parameter int TAG_W   = 4,
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  fpu_cmd_sequencer_if.slave bus,
  output logic busy
`ifdef FPU_SEQ_LATENCY_EN
  ,
  output logic [7:0]  rsp_latency,
  output logic [15:0] stat_timeouts
`endif
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
  localparam logic [CW-1:0] TMO_LAST    = CW'(TIMEOUT - 1);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, DRAIN} state_t;
  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic          accept, legal, done_hit, tmo_hit, rsp_hs, is_mul;
`ifdef FPU_SEQ_LATENCY_EN
  logic [7:0]    lat_val;
`endif
  assign busy          = state != IDLE;
  assign bus.req_ready = state == IDLE;
  always_comb begin
    accept   = state == IDLE && bus.req_valid;
    legal    = bus.req_opcode != 3'd0 && bus.req_opcode <= 3'd5;
    done_hit = state == WAIT && bus.alu_done;
    // done in the same cycle as the deadline takes priority
    tmo_hit  = (state == ISSUE || state == WAIT) && cnt == TMO_LAST && !done_hit;
    rsp_hs   = state == RESP && bus.rsp_valid && bus.rsp_ready;
    is_mul   = bus.alu_opcode == 3'd3;
`ifdef FPU_SEQ_LATENCY_EN
    lat_val  = (32'(cnt) + 32'd1 > 32'd255) ? 8'hFF : 8'(32'(cnt) + 32'd1);
`endif
    state_n  = state;
    case (state)
      IDLE:    state_n = accept ? (legal ? ISSUE : RESP) : IDLE;
      ISSUE:   state_n = tmo_hit ? RESP : (cnt == SETTLE_LAST ? WAIT : ISSUE);
      WAIT:    state_n = (done_hit || tmo_hit) ? RESP : WAIT;
      // illegal responses never touched the ALU, so there is no done to drain
      RESP:    state_n = rsp_hs ? (bus.rsp_flags[3] ? IDLE : DRAIN) : RESP;
      DRAIN:   state_n = cnt == CW'(1) ? IDLE : DRAIN;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_n;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt            <= '0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_result <= '0;
      bus.rsp_flags  <= '0;
      bus.rsp_tag    <= '0;
      bus.alu_opcode <= '0;
      bus.alu_op_a   <= '0;
      bus.alu_op_b   <= '0;
`ifdef FPU_SEQ_LATENCY_EN
      rsp_latency    <= '0;
      stat_timeouts  <= '0;
`endif
    end else begin
      // one counter serves settle, timeout (continues ISSUE->WAIT) and drain
      cnt <= (state_n != state && (state_n == ISSUE || state_n == DRAIN)) ? '0 : cnt + 1'b1;
      if (accept) bus.rsp_tag <= bus.req_tag;
      if (accept && legal) begin
        bus.alu_opcode <= bus.req_opcode;
        bus.alu_op_a   <= bus.req_a;
        bus.alu_op_b   <= bus.req_b;
      end
      if (accept && !legal) begin
        bus.rsp_valid  <= 1'b1;
        bus.rsp_result <= '0;
        bus.rsp_flags  <= 5'b01000;
`ifdef FPU_SEQ_LATENCY_EN
        rsp_latency    <= '0;
`endif
      end
      if (done_hit) begin
        bus.rsp_valid  <= 1'b1;
        bus.rsp_result <= bus.alu_result;
        // the ALU only refreshes overflow/underflow for MUL; SQRT exception is not meaningful
        bus.rsp_flags  <= {2'b00, is_mul & bus.alu_underflow, is_mul & bus.alu_overflow,
                           bus.alu_opcode != 3'd5 && bus.alu_exception};
`ifdef FPU_SEQ_LATENCY_EN
        rsp_latency    <= lat_val;
`endif
      end else if (tmo_hit) begin
        bus.rsp_valid  <= 1'b1;
        bus.rsp_result <= '0;
        bus.rsp_flags  <= 5'b10000;
`ifdef FPU_SEQ_LATENCY_EN
        rsp_latency    <= lat_val;
        stat_timeouts  <= stat_timeouts == 16'hFFFF ? stat_timeouts : stat_timeouts + 16'd1;
`endif
      end
      if (rsp_hs) begin
        bus.rsp_valid  <= 1'b0;
        bus.alu_opcode <= '0;
      end
    end
  end
endmodule

// File: doc/fpu_cmd_sequencer.md
Name: fpu_cmd_sequencer

Overview:
- Initiator side of the FPU ALU command interface. Accepts one floating-point request at a time on a valid/ready port and drives opcode and operands to the ALU.
- Holds opcode and operands stable until the ALU asserts done, then captures result and flags. Returns them on a valid/ready response port with a caller tag.
- Sits between the instruction/bus front-end and the ALU.
- Guards against a stale done from the previous operation, illegal opcodes, and hung multi-cycle ops (div/sqrt).

Parameters:
- TAG_W, 4, width of request/response tag.
- SETTLE, 2, cycles after issue during which alu_done is ignored (min 1).
- TIMEOUT, 64, max cycles from issue to alu_done before forced error response.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept request
- req_opcode  in  3  1=ADD 2=SUB 3=MUL 4=DIV 5=SQRT
- req_a  in  32  IEEE-754 single operand A
- req_b  in  32  IEEE-754 single operand B (ignored for SQRT)
- req_tag  in  TAG_W  caller tag
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  32  captured result
- rsp_flags  out  5  {timeout, illegal, underflow, overflow, exception}
- rsp_tag  out  TAG_W  tag of the request
- alu_opcode  out  3  opcode to ALU; 0 = idle
- alu_op_a  out  32  operand A to ALU
- alu_op_b  out  32  operand B to ALU
- alu_result  in  32  ALU result
- alu_exception  in  1  ALU exception
- alu_overflow  in  1  ALU overflow
- alu_underflow  in  1  ALU underflow
- alu_done  in  1  ALU completion, registered in ALU
- busy  out  1  state != IDLE

Behaviour:
- Clock and reset: reset is asynchronous, active-high; clock is clk, rising edge.
- Reset values:
  - State IDLE.
  - req_ready=1 after reset deasserts.
  - rsp_valid=0; rsp_result=0; rsp_flags=0; rsp_tag=0.
  - alu_opcode=0; alu_op_a=0; alu_op_b=0.
  - busy=0; counters=0.
- Reset mid-operation: aborts immediately to the reset values. No response is emitted for the in-flight request.
- States: IDLE, ISSUE, WAIT, RESP, DRAIN.
- IDLE:
  - req_ready=1; alu_opcode=0.
  - Accept on req_valid&&req_ready at cycle T.
  - Legal opcode (1..5): latch opcode, a, b and tag. Go to ISSUE at T+1, with alu_opcode/op_a/op_b driven from T+1.
  - Illegal opcode (0, 6, 7): no ALU issue. Go to RESP with rsp_result=0 and flags=5'b01000, giving rsp_valid at T+1.
- ISSUE:
  - Holds alu_* stable; alu_done is ignored.
  - Stays for exactly SETTLE cycles, then goes to WAIT.
- WAIT:
  - Samples alu_done every cycle.
  - On alu_done=1 at cycle C, capture alu_result, exception, overflow and underflow; go to RESP; rsp_valid=1 from C+1.
  - overflow/underflow are forced to 0 unless the opcode is MUL. The ALU only updates them for MUL.
  - SQRT: exception forced to 0.
- Timeout:
  - Counter starts at 0 on entry to ISSUE and increments every ISSUE/WAIT cycle.
  - If it reaches TIMEOUT-1 without a qualifying done, go to RESP with result=0 and flags=5'b10000.
  - Done and timeout in the same cycle: done wins.
- RESP:
  - rsp_* held stable while rsp_valid && !rsp_ready.
  - alu_* keep their issue values.
  - On rsp_valid&&rsp_ready: rsp_valid drops next cycle. Go to DRAIN, or to IDLE directly if the response was illegal.
- DRAIN:
  - alu_opcode=0 for 2 cycles so the ALU clears its registered done; then IDLE.
  - req_ready=0 in every state except IDLE.
- Throughput: no overlap; one request outstanding.
  - Minimum legal-op occupancy is 1 (accept) + SETTLE + 1 (done) + 1 (resp) + 2 (drain) cycles, assuming immediate rsp_ready.
- req_* inputs may change freely after the accepting cycle; they are latched at accept.

Optional Feature:
- Macro: FPU_SEQ_LATENCY_EN.
- Defined:
  - Adds output port rsp_latency, 8 bits: number of cycles from ISSUE entry to done/timeout capture, saturating at 255.
  - Valid alongside rsp_valid; 0 for illegal responses; reset 0.
  - Adds output port stat_timeouts, 16 bits: total timeouts since reset, saturating at 0xFFFF.
- Undefined: neither port exists; behaviour is otherwise identical.

Test Plan:
- ADD, a=0x3F800000, b=0x40000000, ALU model returns 0x40400000 with done after 1 cycle:
  - rsp_result=0x40400000, flags=0, tag echoed; req_ready low until DRAIN ends.
- MUL, a=0x7F000000, b=0x7F000000, ALU returns overflow=1:
  - flags=5'b00010.
- SUB, with stale overflow=1 held from the prior MUL:
  - flags overflow bit=0.
- req_opcode=3'b111, tag=5:
  - rsp_valid at T+1, flags=5'b01000, rsp_tag=5; alu_opcode stays 0 throughout.
- DIV with alu_done tied 0, TIMEOUT=64:
  - response after exactly 64 ISSUE/WAIT cycles, flags=5'b10000, result=0.
- SQRT, done after 10 cycles, rsp_ready low for 5 cycles:
  - rsp_* stable for those 5 cycles.
- Reset asserted in WAIT:
  - outputs return to reset values in the same cycle (async); no response is ever delivered for that request.
